// File: rtl/tdc_pkg.sv
// Shared types and helpers for the coarse-phase decode path.
// Holds the default counter width, FSM states and A/B pair check.
package tdc_pkg;

    localparam int CNT_W_DEF = 3;
    localparam int CNT_MAX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_HOLD
    } state_e;

    // B samples on the inverted clock, so it may trail A by one count.
    function automatic logic cnt_pair_ok(
        input logic [CNT_MAX_W-1:0] a,
        input logic [CNT_MAX_W-1:0] b,
        input int                   w
    );
        logic [CNT_MAX_W-1:0] mask;
        logic [CNT_MAX_W-1:0] diff;
        mask = (CNT_MAX_W'(1) << w) - CNT_MAX_W'(1);
        diff = (a - b) & mask;
        return (diff == '0) || (diff == CNT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/coarse_phase_decoder_if.sv
// Hit snapshot input, decoded result output and overflow flag.
// The decoder sits on the master side; the encoder/source on slave.
interface coarse_phase_decoder_if
    import tdc_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W_DEF
);

    logic                 Hit_Valid;
    logic [CNT_WIDTH-1:0] TOA_CntA;
    logic [CNT_WIDTH-1:0] TOA_CntB;
    logic [CNT_WIDTH-1:0] TOT_CntA;
    logic [CNT_WIDTH-1:0] TOT_CntB;
    logic                 TOA_Sel;
    logic                 TOT_Sel;

    logic                 Out_Valid;
    logic                 Out_Ready;
    logic [CNT_WIDTH-1:0] TOA_Coarse;
    logic [CNT_WIDTH-1:0] TOT_Coarse;
    logic                 Coarse_Err;
    logic                 Overflow;

    modport master (
        input  Hit_Valid,
        input  TOA_CntA,
        input  TOA_CntB,
        input  TOT_CntA,
        input  TOT_CntB,
        input  TOA_Sel,
        input  TOT_Sel,
        output Out_Valid,
        input  Out_Ready,
        output TOA_Coarse,
        output TOT_Coarse,
        output Coarse_Err,
        output Overflow
    );

    modport slave (
        output Hit_Valid,
        output TOA_CntA,
        output TOA_CntB,
        output TOT_CntA,
        output TOT_CntB,
        output TOA_Sel,
        output TOT_Sel,
        input  Out_Valid,
        output Out_Ready,
        input  TOA_Coarse,
        input  TOT_Coarse,
        input  Coarse_Err,
        input  Overflow
    );

endinterface

// File: rtl/coarse_sel_check.sv
// Picks counter A or B for one edge and flags an inconsistent pair.
// Purely combinational; used once for TOA and once for TOT.
module coarse_sel_check
    import tdc_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W_DEF
) (
    input  logic [CNT_WIDTH-1:0] cnt_a,
    input  logic [CNT_WIDTH-1:0] cnt_b,
    input  logic                 sel,
    output logic [CNT_WIDTH-1:0] code,
    output logic                 ok
);

    assign code = sel ? cnt_b : cnt_a;
    assign ok   = cnt_pair_ok(CNT_MAX_W'(cnt_a),
                              CNT_MAX_W'(cnt_b),
                              CNT_WIDTH);

endmodule

// File: rtl/coarse_phase_decoder.sv
// Coarse TOA/TOT decode from dual ripple-counter snapshots.
// Define COARSE_ERR_CNT_EN to add the saturating Err_Cnt output.
module coarse_phase_decoder
    import tdc_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    coarse_phase_decoder_if.master bus
`ifdef COARSE_ERR_CNT_EN
    ,
    output logic [7:0]            Err_Cnt
`endif
);

    state_e               state_q, state_d;

    logic [CNT_WIDTH-1:0] toa_a_q, toa_a_d;
    logic [CNT_WIDTH-1:0] toa_b_q, toa_b_d;
    logic [CNT_WIDTH-1:0] tot_a_q, tot_a_d;
    logic [CNT_WIDTH-1:0] tot_b_q, tot_b_d;
    logic                 toa_sel_q, toa_sel_d;
    logic                 tot_sel_q, tot_sel_d;

    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] toa_coarse_q, toa_coarse_d;
    logic [CNT_WIDTH-1:0] tot_coarse_q, tot_coarse_d;
    logic                 coarse_err_q, coarse_err_d;
    logic                 overflow_q, overflow_d;

    logic [CNT_WIDTH-1:0] toa_code;
    logic [CNT_WIDTH-1:0] tot_code;
    logic                 toa_ok;
    logic                 tot_ok;
    logic                 decode_err;

    coarse_sel_check #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_toa_chk (
        .cnt_a (toa_a_q),
        .cnt_b (toa_b_q),
        .sel   (toa_sel_q),
        .code  (toa_code),
        .ok    (toa_ok)
    );

    coarse_sel_check #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tot_chk (
        .cnt_a (tot_a_q),
        .cnt_b (tot_b_q),
        .sel   (tot_sel_q),
        .code  (tot_code),
        .ok    (tot_ok)
    );

    assign decode_err = ~(toa_ok & tot_ok);

    always_comb begin
        state_d      = state_q;
        toa_a_d      = toa_a_q;
        toa_b_d      = toa_b_q;
        tot_a_d      = tot_a_q;
        tot_b_d      = tot_b_q;
        toa_sel_d    = toa_sel_q;
        tot_sel_d    = tot_sel_q;
        out_valid_d  = out_valid_q;
        toa_coarse_d = toa_coarse_q;
        tot_coarse_d = tot_coarse_q;
        coarse_err_d = coarse_err_q;
        overflow_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Hit_Valid) begin
                    toa_a_d   = bus.TOA_CntA;
                    toa_b_d   = bus.TOA_CntB;
                    tot_a_d   = bus.TOT_CntA;
                    tot_b_d   = bus.TOT_CntB;
                    toa_sel_d = bus.TOA_Sel;
                    tot_sel_d = bus.TOT_Sel;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                overflow_d   = bus.Hit_Valid;
                toa_coarse_d = toa_code;
                tot_coarse_d = tot_code - toa_code;
                coarse_err_d = decode_err;
                out_valid_d  = 1'b1;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                // No back-to-back acceptance: a hit here is always lost.
                overflow_d = bus.Hit_Valid;
                if (bus.Out_Ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            toa_a_q      <= '0;
            toa_b_q      <= '0;
            tot_a_q      <= '0;
            tot_b_q      <= '0;
            toa_sel_q    <= 1'b0;
            tot_sel_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            toa_coarse_q <= '0;
            tot_coarse_q <= '0;
            coarse_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            toa_a_q      <= toa_a_d;
            toa_b_q      <= toa_b_d;
            tot_a_q      <= tot_a_d;
            tot_b_q      <= tot_b_d;
            toa_sel_q    <= toa_sel_d;
            tot_sel_q    <= tot_sel_d;
            out_valid_q  <= out_valid_d;
            toa_coarse_q <= toa_coarse_d;
            tot_coarse_q <= tot_coarse_d;
            coarse_err_q <= coarse_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.Out_Valid  = out_valid_q;
    assign bus.TOA_Coarse = toa_coarse_q;
    assign bus.TOT_Coarse = tot_coarse_q;
    assign bus.Coarse_Err = coarse_err_q;
    assign bus.Overflow   = overflow_q;

`ifdef COARSE_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == ST_DECODE && decode_err
            && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Err_Cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_coarse_phase_decoder.sv
// Directed bench for coarse_phase_decoder with hand-computed vectors.
// Define COARSE_ERR_CNT_EN to also exercise Err_Cnt.
module tb_coarse_phase_decoder;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;
    int   xfer_cnt;
    logic [10:0] got;
    logic [10:0] exp_v;

    coarse_phase_decoder_if #(.CNT_WIDTH(3)) bus ();

`ifdef COARSE_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    coarse_phase_decoder #(
        .CNT_WIDTH (3)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
`ifdef COARSE_ERR_CNT_EN
        ,
        .Err_Cnt (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.Out_Valid && bus.Out_Ready) xfer_cnt = xfer_cnt + 1;
    end

    // {valid, toa, tot, err, ovf}
    assign got = {1'b0, bus.Out_Valid, bus.TOA_Coarse,
                  bus.TOT_Coarse, bus.Coarse_Err, bus.Overflow, 1'b0};

    function automatic logic [10:0] pack(
        input logic v, input logic [2:0] toa, input logic [2:0] tot,
        input logic e, input logic o);
        return {1'b0, v, toa, tot, e, o, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hit(
        input logic [2:0] ta, input logic [2:0] tb, input logic ts,
        input logic [2:0] oa, input logic [2:0] ob, input logic os);
        bus.TOA_CntA = ta;
        bus.TOA_CntB = tb;
        bus.TOA_Sel  = ts;
        bus.TOT_CntA = oa;
        bus.TOT_CntB = ob;
        bus.TOT_Sel  = os;
    endtask

    task automatic send_hit();
        bus.Hit_Valid = 1'b1;
        tick();
        bus.Hit_Valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        nvec++;
        exp_v = pack(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL reset_state got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_reset_mid_hold();
        bus.Out_Ready = 1'b0;
        set_hit(3'd5, 3'd5, 1'b0, 3'd2, 3'd2, 1'b0);
        send_hit();
        tick();
        nvec++;
        exp_v = pack(1'b1, 3'd5, 3'd5, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL pre_reset_hold got=%h want=%h", got, exp_v);
        end
        rst = 1'b1;
        bus.Hit_Valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.Hit_Valid = 1'b0;
        nvec++;
        exp_v = pack(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL reset_mid_hold got=%h want=%h", got, exp_v);
        end
        bus.Out_Ready = 1'b1;
        set_hit(3'd1, 3'd0, 1'b1, 3'd4, 3'd4, 1'b0);
        send_hit();
        tick();
        nvec++;
        exp_v = pack(1'b1, 3'd0, 3'd4, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL after_reset_decode got=%h want=%h", got, exp_v);
        end
        tick();
    endtask

    task automatic test_basic();
        bus.Out_Ready = 1'b1;
        set_hit(3'd3, 3'd3, 1'b0, 3'd6, 3'd5, 1'b1);
        send_hit();
        nvec++;
        if (bus.Out_Valid !== 1'b0) begin
            nerr++;
            $display("FAIL basic_n1_valid got=%b want=0", bus.Out_Valid);
        end
        tick();
        nvec++;
        exp_v = pack(1'b1, 3'd3, 3'd2, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL basic_decode got=%h want=%h", got, exp_v);
        end
        tick();
        nvec++;
        if (bus.Out_Valid !== 1'b0) begin
            nerr++;
            $display("FAIL basic_one_cycle got=%b want=0", bus.Out_Valid);
        end
    endtask

    task automatic test_wrap();
        bus.Out_Ready = 1'b1;
        set_hit(3'd7, 3'd7, 1'b0, 3'd1, 3'd0, 1'b0);
        send_hit();
        tick();
        nvec++;
        exp_v = pack(1'b1, 3'd7, 3'd2, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL wrap_7_to_1 got=%h want=%h", got, exp_v);
        end
        tick();
        set_hit(3'd0, 3'd7, 1'b0, 3'd0, 3'd0, 1'b0);
        send_hit();
        tick();
        nvec++;
        exp_v = pack(1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL wrap_a0_b7 got=%h want=%h", got, exp_v);
        end
        tick();
        set_hit(3'd4, 3'd4, 1'b1, 3'd4, 3'd4, 1'b0);
        send_hit();
        tick();
        nvec++;
        exp_v = pack(1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL toa_eq_tot got=%h want=%h", got, exp_v);
        end
        tick();
    endtask

    task automatic test_err();
        bus.Out_Ready = 1'b1;
        set_hit(3'd2, 3'd5, 1'b0, 3'd4, 3'd4, 1'b0);
        send_hit();
        tick();
        nvec++;
        exp_v = pack(1'b1, 3'd2, 3'd2, 1'b1, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL toa_pair_err got=%h want=%h", got, exp_v);
        end
        tick();
        set_hit(3'd6, 3'd6, 1'b0, 3'd3, 3'd5, 1'b1);
        send_hit();
        tick();
        nvec++;
        exp_v = pack(1'b1, 3'd6, 3'd7, 1'b1, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL tot_pair_err got=%h want=%h", got, exp_v);
        end
        tick();
`ifdef COARSE_ERR_CNT_EN
        nvec++;
        if (err_cnt !== 8'd2) begin
            nerr++;
            $display("FAIL err_cnt_two got=%0d want=2", err_cnt);
        end
        set_hit(3'd2, 3'd5, 1'b0, 3'd4, 3'd4, 1'b0);
        for (int i = 0; i < 298; i++) begin
            send_hit();
            tick();
            tick();
        end
        nvec++;
        if (err_cnt !== 8'd255) begin
            nerr++;
            $display("FAIL err_cnt_sat got=%0d want=255", err_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        int x0;
        bus.Out_Ready = 1'b0;
        x0 = xfer_cnt;
        set_hit(3'd5, 3'd4, 1'b1, 3'd1, 3'd1, 1'b0);
        send_hit();
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.Hit_Valid = (i == 1);
            if (i == 1) set_hit(3'd0, 3'd3, 1'b0, 3'd6, 3'd6, 1'b1);
            tick();
            bus.Hit_Valid = 1'b0;
            nvec++;
            exp_v = pack(1'b1, 3'd4, 3'd5, 1'b0, i == 1);
            if (got !== exp_v) begin
                nerr++;
                $display("FAIL hold_cyc%0d got=%h want=%h", i, got, exp_v);
            end
        end
        bus.Out_Ready = 1'b1;
        bus.Hit_Valid = 1'b1;
        tick();
        bus.Hit_Valid = 1'b0;
        nvec++;
        exp_v = pack(1'b0, 3'd4, 3'd5, 1'b0, 1'b1);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL xfer_drop got=%h want=%h", got, exp_v);
        end
        tick();
        tick();
        nvec++;
        exp_v = pack(1'b0, 3'd4, 3'd5, 1'b0, 1'b0);
        if (got !== exp_v) begin
            nerr++;
            $display("FAIL dropped_not_decoded got=%h want=%h", got, exp_v);
        end
        nvec++;
        if (xfer_cnt - x0 !== 1) begin
            nerr++;
            $display("FAIL bp_xfers got=%0d want=1", xfer_cnt - x0);
        end
    endtask

    task automatic test_throughput();
        int x0;
        logic [2:0] ta, tb, oa, ob, toa, tot;
        logic ts, os;
        bus.Out_Ready = 1'b1;
        x0 = xfer_cnt;
        for (int k = 0; k < 20; k++) begin
            ta = 3'(k);
            tb = k[0] ? ta - 3'd1 : ta;
            ts = k[1];
            oa = 3'(3 * k + 1);
            ob = k[2] ? oa - 3'd1 : oa;
            os = k[0];
            toa = ts ? tb : ta;
            tot = os ? ob : oa;
            set_hit(ta, tb, ts, oa, ob, os);
            send_hit();
            tick();
            nvec++;
            exp_v = pack(1'b1, toa, tot - toa, 1'b0, 1'b0);
            if (got !== exp_v) begin
                nerr++;
                $display("FAIL tput_hit%0d got=%h want=%h", k, got, exp_v);
            end
            tick();
        end
        nvec++;
        if (xfer_cnt - x0 !== 20) begin
            nerr++;
            $display("FAIL tput_xfers got=%0d want=20", xfer_cnt - x0);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        xfer_cnt = 0;
        rst = 1'b1;
        bus.Hit_Valid = 1'b0;
        bus.Out_Ready = 1'b0;
        set_hit(3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        #1;
        test_reset();
        test_reset_mid_hold();
        test_basic();
        test_wrap();
        test_backpressure();
        test_throughput();
        test_err();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/coarse_phase_decoder.md
Name: coarse_phase_decoder

Overview:
Downstream stage of the dual ripple-counter coarse-phase capture (counters A and B, B clocked on the inverted clock). Consumes the latched TOA/TOT counter A/B snapshots plus a per-hit half-cycle select from the fine TDC. Produces a single corrected TOA coarse code and a TOT-minus-TOA coarse width. Checks A/B consistency and delivers results over a valid/ready handshake to the TDC encoder.

Parameters:
CNT_WIDTH, 3, width of each ripple-counter snapshot and of the coarse outputs; arithmetic is modulo 2^CNT_WIDTH

Ports:
CLK  input  1  system clock; all logic on posedge
RST  input  1  synchronous, active-high reset
Hit_Valid  input  1  one-cycle pulse; snapshots and select are stable this cycle
TOA_CntA  input  CNT_WIDTH  TOA snapshot of counter A
TOA_CntB  input  CNT_WIDTH  TOA snapshot of counter B
TOT_CntA  input  CNT_WIDTH  TOT snapshot of counter A
TOT_CntB  input  CNT_WIDTH  TOT snapshot of counter B
TOA_Sel  input  1  0 = use counter A for TOA, 1 = use counter B
TOT_Sel  input  1  same, for TOT
Out_Valid  output  1  result available
Out_Ready  input  1  downstream accepts when Out_Valid & Out_Ready
TOA_Coarse  output  CNT_WIDTH  selected TOA code
TOT_Coarse  output  CNT_WIDTH  (TOT code - TOA code) mod 2^CNT_WIDTH
Coarse_Err  output  1  A/B inconsistency on TOA or TOT for this result
Overflow  output  1  one-cycle pulse: Hit_Valid dropped because busy

Behaviour:
- Reset (RST=1 at posedge): state IDLE. Out_Valid, TOA_Coarse, TOT_Coarse, Coarse_Err and Overflow are all 0. Any held result is discarded. Reset wins over every other event in the same cycle.
- FSM states: IDLE, DECODE, HOLD.
- IDLE + Hit_Valid: register all four snapshots and both selects; go to DECODE.
- DECODE, one cycle:
  - toa = TOA_Sel ? TOA_CntB : TOA_CntA; tot = TOT_Sel ? TOT_CntB : TOT_CntA.
  - TOT_Coarse = tot - toa, truncated to CNT_WIDTH (wrap, never saturate).
  - Consistency rule: valid iff B == A or B == A-1 (mod 2^CNT_WIDTH). Coarse_Err = TOA pair invalid OR TOT pair invalid.
  - Load the output registers, set Out_Valid=1, go to HOLD.
- Latency: Hit_Valid at cycle n gives Out_Valid=1 at cycle n+2.
- HOLD: outputs stay frozen while Out_Valid=1 and Out_Ready=0. When Out_Ready=1, the transfer completes; next cycle Out_Valid=0 and state is IDLE.
- Out_Ready may be high before Out_Valid rises. Transfer then completes in the first HOLD cycle, so Out_Valid is high for exactly 1 cycle.
- Hit_Valid in DECODE or HOLD: hit is dropped and Overflow pulses the next cycle. This includes the HOLD cycle in which the transfer completes, because there is no back-to-back acceptance. Held data is unaffected.
- Hit_Valid in IDLE always accepted. Minimum hit spacing is 3 cycles with Out_Ready tied high.
- Wrap cases: toa=7, tot=1 gives TOT_Coarse=2. toa==tot gives 0. A=0, B=7 is consistent.

Optional Feature:
COARSE_ERR_CNT_EN
- When defined: adds output Err_Cnt [7:0], a saturating count of accepted results with Coarse_Err=1. It increments on the DECODE cycle, holds at 255, and clears on RST.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (tdc_pkg): CNT_WIDTH default, the FSM state enum, and the consistency-check function (A, B -> ok).
- One sub-module: coarse_sel_check. It takes A, B and Sel and returns the selected code and the ok flag. It is instantiated twice (TOA, TOT) and is purely combinational.

Test Plan:
- Reset mid-HOLD: hit accepted, Out_Ready=0, assert RST. Next cycle all outputs are 0, state is IDLE, and a following hit is decoded normally.
- Basic decode: TOA A=3, B=3, Sel=0; TOT A=6, B=5, Sel=1. Out_Valid at n+2 with TOA_Coarse=3, TOT_Coarse=2, Coarse_Err=0.
- Wrap: TOA A=7, B=7, Sel=0; TOT A=1, B=0, Sel=0. Result TOT_Coarse=2. Then TOA A=0, B=7: Coarse_Err=0.
- Inconsistent pair: TOA A=2, B=5 gives Coarse_Err=1. With COARSE_ERR_CNT_EN, Err_Cnt increments by 1; after 300 such hits it reads 255.
- Backpressure and overflow: Out_Ready=0 for 5 cycles. Outputs are stable throughout. A Hit_Valid during HOLD gives an Overflow pulse, no data change, and a single transfer on Out_Ready=1.
- Throughput: Out_Ready tied high, hits every 3 cycles for 20 hits. This produces 20 results in order with no Overflow.
